regfile_port_arbiter: RTL and testbench
=======================================

// Module: regfile_port_arbiter
// PURPOSE
//  Shares the single read port and single masked-write port of the 256x512b per-warp
//  register-file RAM (16 lanes x 32b) between multiple requesters.
//  Sits between the operand collectors / writeback units and the regfile RAM macro.
//  Round-robin arbitration with valid/ready on requests; fixed 1-cycle read response.
// PARAMETERS
//  NUM_RD    4    read requesters (operand collectors), >=2
//  NUM_WR    2    write requesters (ALU/LSU writeback), >=2
//  ADDR_W    8    RAM address width (256 entries)
//  LANES     16   32-bit lanes per entry; data width DW = LANES*32 = 512
// PORTS
//  clock          in   1            single clock, drives arbiter and RAM
//  reset          in   1            synchronous, active-high
//  rd_req_valid   in   NUM_RD       per-requester read request
//  rd_req_addr    in   NUM_RD*8     flattened; requester i at [i*8 +: 8]
//  rd_req_ready   out  NUM_RD       one-hot grant, combinational from rd_req_valid
//  rd_resp_valid  out  NUM_RD       one-hot, asserted 1 cycle after grant
//  rd_resp_data   out  DW           shared response bus (= ram_R0_data)
//  wr_req_valid   in   NUM_WR       per-source write request
//  wr_req_addr    in   NUM_WR*8     flattened
//  wr_req_data    in   NUM_WR*DW    flattened
//  wr_req_mask    in   NUM_WR*16    per-lane write enable
//  wr_req_ready   out  NUM_WR       one-hot grant, combinational from wr_req_valid
//  ram_R0_en/addr out  1/8          to RAM read port
//  ram_R0_data    in   DW           from RAM, valid cycle after ram_R0_en
//  ram_W0_en/addr out  1/8          to RAM write port
//  ram_W0_data    out  DW
//  ram_W0_mask    out  16
//  perf_rd_conflicts out 32         see CONFIGURATION
//  perf_wr_conflicts out 32         see CONFIGURATION
// BEHAVIOUR
//  - Handshake: transfer when valid&&ready same cycle; requester holds valid/addr/data
//    stable until ready. At most one read and one write granted per cycle.
//  - Read RR: ptr_rd = last granted index. Grant = first valid index after ptr_rd,
//    wrapping NUM_RD-1 -> 0. ptr_rd updates only on a grant. Reset: ptr_rd = NUM_RD-1.
//  - Write RR: identical, independent pointer ptr_wr, reset NUM_WR-1.
//  - Read path: on grant, ram_R0_en=1, ram_R0_addr=granted addr (combinational).
//    Next cycle rd_resp_valid = registered grant one-hot; rd_resp_data = ram_R0_data.
//    No backpressure on response; consumer must accept. Back-to-back grants every cycle.
//  - Write path: on grant, ram_W0_en=1 and addr/data/mask muxed from winner same cycle.
//    Mask 16'h0000 still a handshake (consumes grant), RAM unchanged.
//  - Ordering: read and write same addr same cycle -> response returns NEW data
//    (write-first). Write granted in the response cycle does not alter that response.
//  - Idle: no valid -> ram_R0_en=0, ram_W0_en=0, addr/data/mask outputs 0.
//  - Reset values: rd_resp_valid=0, pointers as above, perf counters 0; ready outputs
//    forced 0 while reset high. Reset mid-read drops the pending response (no valid).
// CONFIGURATION
//  REGFILE_ARB_PERF_EN defined: perf_rd_conflicts increments (saturating at 2^32-1)
//    each cycle with >=2 rd_req_valid bits set; perf_wr_conflicts likewise for writes.
//  Not defined: no counter registers; both perf ports tied to 32'h0.
// TESTING
//  1 Single read: rd_req_valid=4'b0100, addr 8'h2A after write 8'h2A=0x55..55 mask FFFF
//    -> ready=0100 same cycle; next cycle resp_valid=0100, data=0x55..55.
//  2 RR fairness: all 4 rd valid held 8 cycles after reset -> grants 0,1,2,3,0,1,2,3;
//    with PERF_EN perf_rd_conflicts=8.
//  3 Masked write: wr src1 addr 8'h10 data all 0xFFFFFFFF mask 16'h0003 over zeros
//    -> readback lanes 0-1 = FFFFFFFF, lanes 2-15 = 0.
//  4 Same-cycle RAW: write 8'h07=0xA5..A5 and read 8'h07 same cycle -> resp = 0xA5..A5.
//  5 Write contention: both wr valid 4 cycles -> grants 1? no: 0,1,0,1; each src
//    data lands once per grant; no grant lost or duplicated.
//  6 Reset mid-op: read granted cycle k, reset high cycle k+1 -> rd_resp_valid=0,
//    next grant after reset goes to index 0.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter
//
// Shares the single read port and the single masked-write port of the
// per-warp register-file RAM (256 entries x LANES x 32b) between several
// operand collectors (readers) and writeback units (writers).
//
// Each port has its own round-robin arbiter. The pointer holds the index that
// was granted last. The next grant goes to the first valid requester after it.
// Grants (the *_ready outputs) are combinational from *_req_valid. The RAM
// control outputs are driven in the same cycle. A read response comes back
// exactly one cycle after its grant. The response has no backpressure.
//
// A read and a write to the same address in the same cycle are write-first:
// the written lanes are captured and merged over the RAM data in the response
// cycle. The design does not assume any same-address behaviour from the RAM.
//
// Optional feature (compile-time macro REGFILE_ARB_PERF_EN):
//   defined     : saturating 32-bit conflict counters. They count cycles with
//                 two or more read (or write) requests valid.
//   not defined : no counter registers; both perf outputs are tied to zero.
//
// Ports
//   clock, reset          single clock; synchronous active-high reset
//   rd_req_valid/addr     per-requester read requests (addr flattened, i at [i*ADDR_W +: ADDR_W])
//   rd_req_ready          one-hot read grant
//   rd_resp_valid/data    one-hot response valid one cycle after the grant; shared data bus
//   wr_req_valid/addr/data/mask   per-source write requests (flattened)
//   wr_req_ready          one-hot write grant
//   ram_R0_en/addr/data   RAM read port (data valid the cycle after en)
//   ram_W0_en/addr/data/mask      RAM masked write port
//   perf_rd_conflicts, perf_wr_conflicts   conflict counters (zero when disabled)
// ---------------------------------------------------------------------------
module regfile_port_arbiter #(
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = 8,
    parameter int LANES  = 16
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic [NUM_RD-1:0]             rd_req_valid,
    input  logic [NUM_RD*ADDR_W-1:0]      rd_req_addr,
    output logic [NUM_RD-1:0]             rd_req_ready,
    output logic [NUM_RD-1:0]             rd_resp_valid,
    output logic [LANES*32-1:0]           rd_resp_data,

    input  logic [NUM_WR-1:0]             wr_req_valid,
    input  logic [NUM_WR*ADDR_W-1:0]      wr_req_addr,
    input  logic [NUM_WR*LANES*32-1:0]    wr_req_data,
    input  logic [NUM_WR*LANES-1:0]       wr_req_mask,
    output logic [NUM_WR-1:0]             wr_req_ready,

    output logic                          ram_R0_en,
    output logic [ADDR_W-1:0]             ram_R0_addr,
    input  logic [LANES*32-1:0]           ram_R0_data,

    output logic                          ram_W0_en,
    output logic [ADDR_W-1:0]             ram_W0_addr,
    output logic [LANES*32-1:0]           ram_W0_data,
    output logic [LANES-1:0]              ram_W0_mask,

    output logic [31:0]                   perf_rd_conflicts,
    output logic [31:0]                   perf_wr_conflicts
);

    localparam int DW    = LANES * 32;
    localparam int RD_PW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int WR_PW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    // Round-robin pointers (index of the last grant).
    logic [RD_PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [WR_PW-1:0]   wr_ptr_q, wr_ptr_d;

    // Response and write-first bypass state.
    logic [NUM_RD-1:0]  rd_resp_valid_q, rd_resp_valid_d;
    logic               byp_hit_q, byp_hit_d;
    logic [DW-1:0]      byp_data_q;
    logic [LANES-1:0]   byp_mask_q;

    // Arbitration results for the current cycle.
    logic               rd_any, wr_any;
    logic [RD_PW-1:0]   rd_gnt_idx;
    logic [WR_PW-1:0]   wr_gnt_idx;
    logic [NUM_RD-1:0]  rd_gnt;
    logic [NUM_WR-1:0]  wr_gnt;

    // ---------------------------------------------------------------
    // Read arbiter: scan from ptr+1 with wrap and take the first valid.
    // No grant is issued while reset is high.
    // ---------------------------------------------------------------
    always_comb begin
        int rd_idx;
        // NOTE: every signal assigned in always_comb gets a default first.
        // Without the default, any path that skips an assignment infers a latch.
        rd_idx     = 0;
        rd_any     = 1'b0;
        rd_gnt_idx = '0;
        for (int k = 1; k <= NUM_RD; k++) begin
            if (!rd_any) begin
                rd_idx = (int'(rd_ptr_q) + k) % NUM_RD;
                if (rd_req_valid[RD_PW'(rd_idx)]) begin
                    rd_any     = 1'b1;
                    rd_gnt_idx = RD_PW'(rd_idx);
                end
            end
        end
        rd_any = rd_any & ~reset;
        rd_gnt = '0;
        if (rd_any) begin
            rd_gnt[rd_gnt_idx] = 1'b1;
        end
    end

    // Write arbiter: the same scheme with its own pointer.
    always_comb begin
        int wr_idx;
        wr_idx     = 0;
        wr_any     = 1'b0;
        wr_gnt_idx = '0;
        for (int k = 1; k <= NUM_WR; k++) begin
            if (!wr_any) begin
                wr_idx = (int'(wr_ptr_q) + k) % NUM_WR;
                if (wr_req_valid[WR_PW'(wr_idx)]) begin
                    wr_any     = 1'b1;
                    wr_gnt_idx = WR_PW'(wr_idx);
                end
            end
        end
        wr_any = wr_any & ~reset;
        wr_gnt = '0;
        if (wr_any) begin
            wr_gnt[wr_gnt_idx] = 1'b1;
        end
    end

    assign rd_req_ready = rd_gnt;
    assign wr_req_ready = wr_gnt;

    // ---------------------------------------------------------------
    // RAM port muxes. The outputs are all zero when there is no grant.
    // ---------------------------------------------------------------
    always_comb begin
        ram_R0_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_gnt[i]) begin
                ram_R0_addr = rd_req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end
    assign ram_R0_en = rd_any;

    always_comb begin
        ram_W0_addr = '0;
        ram_W0_data = '0;
        ram_W0_mask = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_gnt[i]) begin
                ram_W0_addr = wr_req_addr[i*ADDR_W +: ADDR_W];
                ram_W0_data = wr_req_data[i*DW +: DW];
                ram_W0_mask = wr_req_mask[i*LANES +: LANES];
            end
        end
    end
    assign ram_W0_en = wr_any;

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        rd_ptr_d        = rd_any ? rd_gnt_idx : rd_ptr_q;
        wr_ptr_d        = wr_any ? wr_gnt_idx : wr_ptr_q;
        rd_resp_valid_d = rd_gnt;
        // A same-cycle write to the address being read must show up in the response.
        byp_hit_d       = rd_any && wr_any && (ram_R0_addr == ram_W0_addr);
    end

    // NOTE: sequential state uses non-blocking assignments only. Then every
    // flop samples the pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q        <= RD_PW'(NUM_RD - 1);
            wr_ptr_q        <= WR_PW'(NUM_WR - 1);
            rd_resp_valid_q <= '0;
            byp_hit_q       <= 1'b0;
        end else begin
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_resp_valid_q <= rd_resp_valid_d;
            byp_hit_q       <= byp_hit_d;
        end
    end

    // NOTE: the bypass payload has no reset. It is read only when byp_hit_q is
    // set, and byp_hit_q is reset, so the wide datapath needs no reset.
    always_ff @(posedge clock) begin
        if (byp_hit_d) begin
            byp_data_q <= ram_W0_data;
            byp_mask_q <= ram_W0_mask;
        end
    end

    // The response is masked while reset is high, so a read in flight is dropped.
    assign rd_resp_valid = reset ? '0 : rd_resp_valid_q;

    // Merge the captured write lanes over the RAM output. A write granted in
    // the response cycle itself does not touch the bypass and does not change the response.
    always_comb begin
        rd_resp_data = ram_R0_data;
        if (byp_hit_q) begin
            for (int l = 0; l < LANES; l++) begin
                if (byp_mask_q[l]) begin
                    rd_resp_data[l*32 +: 32] = byp_data_q[l*32 +: 32];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Conflict counters
    // ---------------------------------------------------------------
`ifdef REGFILE_ARB_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic        rd_multi, wr_multi;

    // v & (v-1) clears the lowest set bit. A non-zero result means two or more bits are set.
    assign rd_multi = |(rd_req_valid & (rd_req_valid - NUM_RD'(1)));
    assign wr_multi = |(wr_req_valid & (wr_req_valid - NUM_WR'(1)));

    always_comb begin
        perf_rd_d = perf_rd_q;
        perf_wr_d = perf_wr_q;
        if (rd_multi && (perf_rd_q != 32'hFFFF_FFFF)) begin
            perf_rd_d = perf_rd_q + 32'd1;
        end
        if (wr_multi && (perf_wr_q != 32'hFFFF_FFFF)) begin
            perf_wr_d = perf_wr_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_rd_q <= '0;
            perf_wr_q <= '0;
        end else begin
            perf_rd_q <= perf_rd_d;
            perf_wr_q <= perf_wr_d;
        end
    end

    assign perf_rd_conflicts = perf_rd_q;
    assign perf_wr_conflicts = perf_wr_q;
`else
    assign perf_rd_conflicts = 32'h0;
    assign perf_wr_conflicts = 32'h0;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_port_arbiter
//
// Directed-vector bench for regfile_port_arbiter. A behavioural RAM sits on
// the R0/W0 ports. It is read-first and synchronous, so the arbiter has to
// provide same-cycle write-first forwarding by itself. Expected values are
// written out by hand. When REGFILE_ARB_PERF_EN is defined, the perf
// counters are checked against the cycle counts of the stimulus.
// ---------------------------------------------------------------------------
module tb_regfile_port_arbiter;

    logic           clock = 1'b0;
    logic           reset;
    logic [3:0]     rd_req_valid;
    logic [31:0]    rd_req_addr;
    logic [3:0]     rd_req_ready;
    logic [3:0]     rd_resp_valid;
    logic [511:0]   rd_resp_data;
    logic [1:0]     wr_req_valid;
    logic [15:0]    wr_req_addr;
    logic [1023:0]  wr_req_data;
    logic [31:0]    wr_req_mask;
    logic [1:0]     wr_req_ready;
    logic           ram_R0_en;
    logic [7:0]     ram_R0_addr;
    logic [511:0]   ram_R0_data;
    logic           ram_W0_en;
    logic [7:0]     ram_W0_addr;
    logic [511:0]   ram_W0_data;
    logic [15:0]    ram_W0_mask;
    logic [31:0]    perf_rd_conflicts;
    logic [31:0]    perf_wr_conflicts;

    int n_vec = 0;
    int n_err = 0;

    regfile_port_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .rd_req_valid      (rd_req_valid),
        .rd_req_addr       (rd_req_addr),
        .rd_req_ready      (rd_req_ready),
        .rd_resp_valid     (rd_resp_valid),
        .rd_resp_data      (rd_resp_data),
        .wr_req_valid      (wr_req_valid),
        .wr_req_addr       (wr_req_addr),
        .wr_req_data       (wr_req_data),
        .wr_req_mask       (wr_req_mask),
        .wr_req_ready      (wr_req_ready),
        .ram_R0_en         (ram_R0_en),
        .ram_R0_addr       (ram_R0_addr),
        .ram_R0_data       (ram_R0_data),
        .ram_W0_en         (ram_W0_en),
        .ram_W0_addr       (ram_W0_addr),
        .ram_W0_data       (ram_W0_data),
        .ram_W0_mask       (ram_W0_mask),
        .perf_rd_conflicts (perf_rd_conflicts),
        .perf_wr_conflicts (perf_wr_conflicts)
    );

    always #5 clock = ~clock;

    // Behavioural register-file RAM: read-first, masked write.
    logic [511:0] mem [256];
    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;
        ram_R0_data = '0;
    end
    always @(posedge clock) begin
        logic [511:0] w;
        if (ram_R0_en) ram_R0_data <= mem[ram_R0_addr];
        if (ram_W0_en) begin
            w = mem[ram_W0_addr];
            for (int l = 0; l < 16; l++)
                if (ram_W0_mask[l]) w[l*32 +: 32] = ram_W0_data[l*32 +: 32];
            mem[ram_W0_addr] <= w;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rep(input logic [31:0] w);
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        rd_req_valid = '0;
        rd_req_addr  = '0;
        wr_req_valid = '0;
        wr_req_addr  = '0;
        wr_req_data  = '0;
        wr_req_mask  = '0;
    endtask

    task automatic set_rd(input int i, input logic [7:0] a);
        rd_req_valid[i]       = 1'b1;
        rd_req_addr[i*8 +: 8] = a;
    endtask

    task automatic set_wr(input int i, input logic [7:0] a, input logic [511:0] d,
                          input logic [15:0] m);
        wr_req_valid[i]           = 1'b1;
        wr_req_addr[i*8 +: 8]     = a;
        wr_req_data[i*512 +: 512] = d;
        wr_req_mask[i*16 +: 16]   = m;
    endtask

    // One read from requester i that must be the only one requesting. The
    // grant is checked in the request cycle; valid and data are checked in
    // the response cycle.
    task automatic read_chk(input string tag, input int i, input logic [7:0] a,
                            input logic [511:0] exp);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        clear_inputs();
        set_rd(i, a);
        #1;
        check({tag, "_ready"}, 512'(rd_req_ready), 512'(oh));
        tick();
        clear_inputs();
        check({tag, "_rvalid"}, 512'(rd_resp_valid), 512'(oh));
        check({tag, "_rdata"}, rd_resp_data, exp);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0]   exp_wg [4];
        logic [511:0] lo64;
        int           item [2];

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();

        // Reset state: grants stay low while reset is high, even with requests present.
        rd_req_valid = 4'hF;
        wr_req_valid = 2'b11;
        #1;
        check("rst_rd_ready", 512'(rd_req_ready), 512'(4'b0000));
        check("rst_wr_ready", 512'(wr_req_ready), 512'(2'b00));
        check("rst_rvalid", 512'(rd_resp_valid), 512'(4'b0000));
        check("rst_perf_rd", 512'(perf_rd_conflicts), 512'(32'd0));
        check("rst_perf_wr", 512'(perf_wr_conflicts), 512'(32'd0));
        clear_inputs();
        reset = 1'b0;
        #1;

        // Idle: no requests, so every RAM control output is zero.
        check("idle_r0_en", 512'(ram_R0_en), 512'(1'b0));
        check("idle_w0_en", 512'(ram_W0_en), 512'(1'b0));
        check("idle_r0_addr", 512'(ram_R0_addr), 512'(8'h00));
        check("idle_w0_addr", 512'(ram_W0_addr), 512'(8'h00));
        check("idle_w0_data", ram_W0_data, '0);
        check("idle_w0_mask", 512'(ram_W0_mask), 512'(16'h0000));

        // Single read, preceded by a full-mask write of 0x55.. to 0x2A.
        set_wr(0, 8'h2A, rep(32'h5555_5555), 16'hFFFF);
        #1;
        check("w1_ready", 512'(wr_req_ready), 512'(2'b01));
        check("w1_w0_en", 512'(ram_W0_en), 512'(1'b1));
        check("w1_w0_addr", 512'(ram_W0_addr), 512'(8'h2A));
        check("w1_w0_mask", 512'(ram_W0_mask), 512'(16'hFFFF));
        tick();
        clear_inputs();
        set_rd(2, 8'h2A);
        #1;
        check("r1_r0_en", 512'(ram_R0_en), 512'(1'b1));
        check("r1_r0_addr", 512'(ram_R0_addr), 512'(8'h2A));
        read_chk("r1", 2, 8'h2A, rep(32'h5555_5555));

        // A zero-mask write is still granted and leaves the RAM entry unchanged.
        set_wr(1, 8'h2A, '0, 16'h0000);
        #1;
        check("w0mask_ready", 512'(wr_req_ready), 512'(2'b10));
        tick();
        read_chk("r0mask", 3, 8'h2A, rep(32'h5555_5555));

        // Masked write: only lanes 0-1 of 0x10 become all-ones.
        clear_inputs();
        set_wr(1, 8'h10, {512{1'b1}}, 16'h0003);
        #1;
        check("w3_ready", 512'(wr_req_ready), 512'(2'b10));
        tick();
        lo64 = '0;
        lo64[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        read_chk("r3", 0, 8'h10, lo64);

        // Same-cycle read and write of 0x07 returns the new data. A write
        // granted in the response cycle does not change that response.
        clear_inputs();
        set_wr(0, 8'h07, rep(32'hA5A5_A5A5), 16'hFFFF);
        set_rd(1, 8'h07);
        #1;
        check("raw_rd_ready", 512'(rd_req_ready), 512'(4'b0010));
        check("raw_wr_ready", 512'(wr_req_ready), 512'(2'b01));
        tick();
        clear_inputs();
        set_wr(0, 8'h07, rep(32'h3C3C_3C3C), 16'hFFFF);
        #1;
        check("raw_rvalid", 512'(rd_resp_valid), 512'(4'b0010));
        check("raw_rdata", rd_resp_data, rep(32'hA5A5_A5A5));
        tick();
        read_chk("raw_after", 2, 8'h07, rep(32'h3C3C_3C3C));

        // Write contention after reset: grants alternate 0,1,0,1. Each source
        // moves to its next item only when granted.
        do_reset();
        exp_wg[0] = 2'b01; exp_wg[1] = 2'b10; exp_wg[2] = 2'b01; exp_wg[3] = 2'b10;
        item[0] = 0;
        item[1] = 0;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            for (int s = 0; s < 2; s++)
                set_wr(s, 8'(8'h20 + s*16 + item[s]),
                       rep(32'hD0D0_0000 | 32'(s*16 + item[s])), 16'hFFFF);
            #1;
            check($sformatf("wc_ready%0d", c), 512'(wr_req_ready), 512'(exp_wg[c]));
            for (int s = 0; s < 2; s++)
                if (wr_req_ready[s]) item[s]++;
            tick();
        end
        clear_inputs();
`ifdef REGFILE_ARB_PERF_EN
        check("wc_perf_wr", 512'(perf_wr_conflicts), 512'(32'd4));
`else
        check("wc_perf_wr", 512'(perf_wr_conflicts), 512'(32'd0));
`endif
        read_chk("wc_s0i0", 0, 8'h20, rep(32'hD0D0_0000));
        read_chk("wc_s0i1", 0, 8'h21, rep(32'hD0D0_0001));
        read_chk("wc_s1i0", 0, 8'h30, rep(32'hD0D0_0010));
        read_chk("wc_s1i1", 0, 8'h31, rep(32'hD0D0_0011));
        read_chk("wc_none", 0, 8'h22, '0);

        // Read round-robin after reset: all four requesting gives 0,1,2,3,0,1,2,3.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            for (int i = 0; i < 4; i++) set_rd(i, 8'h2A);
            #1;
            check($sformatf("rr_ready%0d", c), 512'(rd_req_ready), 512'(4'b0001 << (c % 4)));
            tick();
            check($sformatf("rr_rvalid%0d", c), 512'(rd_resp_valid), 512'(4'b0001 << (c % 4)));
        end
        clear_inputs();
`ifdef REGFILE_ARB_PERF_EN
        check("rr_perf_rd", 512'(perf_rd_conflicts), 512'(32'd8));
`else
        check("rr_perf_rd", 512'(perf_rd_conflicts), 512'(32'd0));
`endif
        // The pointer is at 3: with requesters 1 and 3 valid, 1 wins first, then 3.
        rd_req_valid = 4'b1010;
        #1;
        check("rr_skip_a", 512'(rd_req_ready), 512'(4'b0010));
        tick();
        #1;
        check("rr_skip_b", 512'(rd_req_ready), 512'(4'b1000));
        tick();
        clear_inputs();

        // Reset mid-read: the pending response is dropped, and the pointer
        // restarts so that index 0 wins next.
        set_rd(2, 8'h2A);
        #1;
        check("mid_ready", 512'(rd_req_ready), 512'(4'b0100));
        tick();
        clear_inputs();
        reset = 1'b1;
        #1;
        check("mid_rvalid_rst", 512'(rd_resp_valid), 512'(4'b0000));
        tick();
        reset = 1'b0;
        check("mid_rvalid_post", 512'(rd_resp_valid), 512'(4'b0000));
        rd_req_valid = 4'hF;
        #1;
        check("mid_next_gnt", 512'(rd_req_ready), 512'(4'b0001));
        tick();
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
